// File: rtl/uart_rx_16x.sv
// ---------------------------------------------------------------------------
// uart_rx_16x
//
// UART receiver using 16x oversampling. It detects a start bit, confirms it at
// mid-bit, samples DATA_BITS data bits LSB-first, an optional parity bit and
// the stop bit at the middle of each bit, and delivers the byte through a
// one-entry valid/ready holding register.
//
// Parameters
//   DATA_BITS  : data bits per frame, 5..8
//   PARITY_EN  : 1 = a parity bit follows the data bits
//   PARITY_ODD : 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)
//
// Ports
//   clk           : system clock, all logic on the rising edge
//   rst           : synchronous active-high reset
//   baud_tick_16x : one-clk strobe at 16x the baud rate
//   rx            : asynchronous serial line, idle high
//   rx_ready      : consumer accepts rx_data when high together with rx_valid
//   rx_data       : received byte, LSB-aligned, unused MSBs zero
//   rx_valid      : rx_data holds an unconsumed byte
//   frame_err     : one-clk pulse, stop bit sampled low
//   parity_err    : one-clk pulse, parity check failed
//   overrun_err   : one-clk pulse, good byte dropped because rx_valid pending
//   busy          : receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick_16x,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam logic       HAS_PARITY = (PARITY_EN != 0);
  localparam logic       PAR_ODD    = (PARITY_ODD != 0);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic [3:0] MID_TICK   = 4'd15;
  localparam logic [3:0] START_MID  = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  // -------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle level so that leaving
  // reset never looks like a falling edge on the line.
  // -------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FSM. Everything advances only on baud ticks; between ticks the
  // state, counters and shift register hold.
  // -------------------------------------------------------------------------
  state_e     state_q;
  logic [3:0] tick_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       par_bad_q;
  logic       frame_err_q;
  logic       parity_err_q;

  logic       mid_bit;
  logic       par_exp;

  assign mid_bit = (tick_cnt_q == MID_TICK);
  // Expected parity bit: XOR of the received data bits (unused shift bits
  // are zero), inverted for odd parity.
  assign par_exp = (^shift_q) ^ PAR_ODD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses.
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;

      if (baud_tick_16x) begin
        case (state_q)
          IDLE: begin
            if (!rx_s_q) begin
              state_q    <= START;
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              shift_q    <= '0;
              par_bad_q  <= 1'b0;
            end
          end

          START: begin
            if (tick_cnt_q == START_MID) begin
              tick_cnt_q <= '0;
              // A line back high at mid start bit was only a glitch.
              state_q    <= rx_s_q ? IDLE : DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end

          DATA: begin
            if (mid_bit) begin
              shift_q[bit_cnt_q] <= rx_s_q;
              tick_cnt_q         <= '0;
              // bit_cnt wraps to 0 after the eighth bit; it is not used again
              // until the next start clears it.
              bit_cnt_q          <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= HAS_PARITY ? PARITY : STOP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end

          PARITY: begin
            if (mid_bit) begin
              par_bad_q  <= (rx_s_q != par_exp);
              tick_cnt_q <= '0;
              state_q    <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end

          STOP: begin
            if (mid_bit) begin
              tick_cnt_q <= '0;
              if (!rx_s_q) begin
                // Framing error wins over parity; wait for the line to
                // return high before hunting for a new start bit.
                frame_err_q <= 1'b1;
                state_q     <= WAIT_IDLE;
              end else begin
                parity_err_q <= par_bad_q;
                state_q      <= IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end

          WAIT_IDLE: begin
            if (rx_s_q) begin
              state_q <= IDLE;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Delivery / holding register. A good byte is recognised on the stop-bit
  // sampling tick and lands in rx_data on that same edge, so it is visible
  // one clk after the tick.
  // -------------------------------------------------------------------------
  logic       good_byte;
  logic       rx_valid_q;
  logic       rx_valid_d;
  logic [7:0] rx_data_q;
  logic [7:0] rx_data_d;
  logic       overrun_q;
  logic       overrun_d;

  assign good_byte = baud_tick_16x && (state_q == STOP) && mid_bit &&
                     rx_s_q && !par_bad_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    overrun_d  = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (good_byte) begin
      // The slot is free if empty or being emptied in this very cycle.
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d = 1'b1;
        rx_data_d  = shift_q;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_16x.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_16x
//
// Two receivers share clk/rst/tick: instance 0 is 8N1, instance 1 is 8E1.
// A negedge monitor counts handshake events and error pulses per instance;
// directed sequences, a vector table and randomized frames compare those
// counts and the outputs against values the bench works out itself.
// One bit lasts 16 ticks = 64 clk (tick every 4 clk).
// ---------------------------------------------------------------------------
module tb_uart_rx_16x;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] rx_w = 2'b11;
  logic [1:0] rdy_w = 2'b10;

  wire  [1:0]      valid_w;
  wire  [1:0]      ferr_w;
  wire  [1:0]      perr_w;
  wire  [1:0]      ovr_w;
  wire  [1:0]      busy_w;
  wire  [1:0][7:0] data_w;

  uart_rx_16x #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .baud_tick_16x(tick), .rx(rx_w[0]),
    .rx_ready(rdy_w[0]), .rx_data(data_w[0]), .rx_valid(valid_w[0]),
    .frame_err(ferr_w[0]), .parity_err(perr_w[0]),
    .overrun_err(ovr_w[0]), .busy(busy_w[0])
  );

  uart_rx_16x #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
    .clk(clk), .rst(rst), .baud_tick_16x(tick), .rx(rx_w[1]),
    .rx_ready(rdy_w[1]), .rx_data(data_w[1]), .rx_valid(valid_w[1]),
    .frame_err(ferr_w[1]), .parity_err(perr_w[1]),
    .overrun_err(ovr_w[1]), .busy(busy_w[1])
  );

  // ---------------- clock, cycle counter, tick generator ----------------
  int cyc = 0;
  int tph = 0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tph  = (tph + 1) % 4;
      tick = (tph == 0);
    end
  end

  // ---------------- monitor ----------------
  int         n_rise [2] = '{0, 0};
  int         n_ferr [2] = '{0, 0};
  int         n_perr [2] = '{0, 0};
  int         n_ovr  [2] = '{0, 0};
  int         rise_cyc [2] = '{0, 0};
  logic [7:0] rise_data [2];
  int         n_unstable = 0;
  int         n_wide = 0;
  int         n_multi = 0;

  logic       prev_valid [2] = '{1'b0, 1'b0};
  logic       prev_hs    [2] = '{1'b0, 1'b0};
  logic       prev_ferr  [2] = '{1'b0, 1'b0};
  logic       prev_perr  [2] = '{1'b0, 1'b0};
  logic       prev_ovr   [2] = '{1'b0, 1'b0};
  logic [7:0] prev_data  [2];
  logic       prev_rst = 1'b1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid_w[i] === 1'b1 && !prev_valid[i]) begin
        n_rise[i]++;
        rise_data[i] = data_w[i];
        rise_cyc[i]  = cyc;
      end
      if (prev_valid[i] && !prev_hs[i] && !prev_rst && data_w[i] !== prev_data[i])
        n_unstable++;
      if (ferr_w[i] === 1'b1) n_ferr[i]++;
      if (perr_w[i] === 1'b1) n_perr[i]++;
      if (ovr_w[i]  === 1'b1) n_ovr[i]++;
      if ((ferr_w[i] === 1'b1 && prev_ferr[i]) || (perr_w[i] === 1'b1 && prev_perr[i]) ||
          (ovr_w[i] === 1'b1 && prev_ovr[i]))
        n_wide++;
      if (int'(ferr_w[i] === 1'b1) + int'(perr_w[i] === 1'b1) + int'(ovr_w[i] === 1'b1) > 1)
        n_multi++;
      prev_valid[i] = (valid_w[i] === 1'b1);
      prev_hs[i]    = (valid_w[i] === 1'b1) && rdy_w[i];
      prev_ferr[i]  = (ferr_w[i] === 1'b1);
      prev_perr[i]  = (perr_w[i] === 1'b1);
      prev_ovr[i]   = (ovr_w[i] === 1'b1);
      prev_data[i]  = data_w[i];
    end
    prev_rst = rst;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  int s_rise, s_ferr, s_perr, s_ovr;

  task automatic snap(input int w);
    s_rise = n_rise[w];
    s_ferr = n_ferr[w];
    s_perr = n_perr[w];
    s_ovr  = n_ovr[w];
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Return just after a posedge at which tick was sampled high, so frames
  // sent from here have a fixed phase relative to the tick train.
  task automatic align();
    do @(posedge clk); while (tick !== 1'b1);
    #1;
  endtask

  task automatic consume(input int w);
    rdy_w[w] = 1'b1;
    cycles(1);
    rdy_w[w] = 1'b0;
  endtask

  // Sends start, 8 data bits LSB first, optional parity, stop. The line is
  // left at the stop-bit level on return.
  task automatic send_frame(input int w, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input logic stop);
    rx_w[w] = 1'b0;
    cycles(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx_w[w] = d[i];
      cycles(BIT_CLK);
    end
    if (par_en) begin
      rx_w[w] = par_bit;
      cycles(BIT_CLK);
    end
    rx_w[w] = stop;
    cycles(BIT_CLK);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_rise;
    int         exp_ferr;
  } vec_t;

  vec_t tbl [6];

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  int         n0;
  int         lat;
  logic [7:0] b;
  logic       bad;
  logic       good;
  logic       pb;
  bit         m_pend;
  logic [7:0] m_data;
  int         exp_ovr;
  int         exp_ferr;
  int         base_ovr;
  int         base_ferr;

  initial begin
    tbl[0] = '{8'h00, 1'b1, 1, 0};
    tbl[1] = '{8'hFF, 1'b1, 1, 0};
    tbl[2] = '{8'h55, 1'b1, 1, 0};
    tbl[3] = '{8'h80, 1'b0, 0, 1};
    tbl[4] = '{8'h01, 1'b1, 1, 0};
    tbl[5] = '{8'hC3, 1'b0, 0, 1};

    // Reset state (while rst is high and after release).
    cycles(4);
    check("reset rx_valid", {30'd0, valid_w}, 32'd0);
    check("reset rx_data0", {24'd0, data_w[0]}, 32'd0);
    check("reset busy", {30'd0, busy_w}, 32'd0);
    check("reset err flags", {26'd0, ferr_w, perr_w, ovr_w}, 32'd0);
    rst = 1'b0;
    cycles(8);
    check("idle after reset busy", {30'd0, busy_w}, 32'd0);

    // 0xA5, good stop.
    snap(0);
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    cycles(32);
    check("A5 rx_valid rises once", n_rise[0] - s_rise, 1);
    check("A5 rx_data", {24'd0, data_w[0]}, 32'h0A5);
    check("A5 no error pulses",
          (n_ferr[0] - s_ferr) + (n_perr[0] - s_perr) + (n_ovr[0] - s_ovr), 0);
    check("A5 rx_valid held", {31'd0, valid_w[0]}, 1);
    consume(0);
    cycles(1);
    check("A5 consumed", {31'd0, valid_w[0]}, 0);

    // Table-driven frames.
    for (int k = 0; k < 6; k++) begin
      consume(0);
      snap(0);
      send_frame(0, tbl[k].data, 0, 1'b0, tbl[k].stop);
      rx_w[0] = 1'b1;
      cycles(48);
      check($sformatf("tbl%0d valid rises", k), n_rise[0] - s_rise, tbl[k].exp_rise);
      check($sformatf("tbl%0d frame_err", k), n_ferr[0] - s_ferr, tbl[k].exp_ferr);
      if (tbl[k].exp_rise == 1)
        check($sformatf("tbl%0d rx_data", k), {24'd0, rise_data[0]}, {24'd0, tbl[k].data});
    end
    consume(0);

    // Start glitch: low for 4 ticks, then high.
    snap(0);
    rx_w[0] = 1'b0;
    cycles(16);
    check("glitch busy while low", {31'd0, busy_w[0]}, 1);
    rx_w[0] = 1'b1;
    cycles(12);
    check("glitch busy until mid start", {31'd0, busy_w[0]}, 1);
    cycles(20);
    check("glitch busy returns 0", {31'd0, busy_w[0]}, 0);
    check("glitch no rx_valid", n_rise[0] - s_rise, 0);

    // 0x3C with bad stop, line held low 40 ticks more.
    snap(0);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
    cycles(160);
    check("break frame_err once", n_ferr[0] - s_ferr, 1);
    check("break busy while low", {31'd0, busy_w[0]}, 1);
    rx_w[0] = 1'b1;
    cycles(2);
    check("break busy before rx_s high", {31'd0, busy_w[0]}, 1);
    cycles(8);
    check("break busy cleared", {31'd0, busy_w[0]}, 0);
    check("break no rx_valid", n_rise[0] - s_rise, 0);
    check("break other errs",
          (n_perr[0] - s_perr) + (n_ovr[0] - s_ovr) + (n_ferr[0] - s_ferr), 1);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    snap(1);
    send_frame(1, 8'h07, 1, 1'b0, 1'b1);
    cycles(32);
    check("par0 parity_err once", n_perr[1] - s_perr, 1);
    check("par0 no rx_valid", n_rise[1] - s_rise, 0);
    snap(1);
    send_frame(1, 8'h07, 1, 1'b1, 1'b1);
    cycles(32);
    check("par1 rx_valid", n_rise[1] - s_rise, 1);
    check("par1 rx_data", {24'd0, rise_data[1]}, 32'h07);
    check("par1 no parity_err", n_perr[1] - s_perr, 0);

    // Overrun: ready low, 0x11 then 0x22.
    consume(0);
    snap(0);
    align();
    n0 = cyc;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    cycles(32);
    lat = rise_cyc[0] - n0;
    check("0x11 rx_valid rises", n_rise[0] - s_rise, 1);
    // Detect on the 1st tick after rx_s falls (+4), 8 ticks of start (+32),
    // 9 bit times to the stop sample (+576): valid visible 612 clk later.
    check("delivery latency", lat, 612);
    snap(0);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1);
    cycles(32);
    check("overrun keeps rx_data", {24'd0, data_w[0]}, 32'h11);
    check("overrun pulse once", n_ovr[0] - s_ovr, 1);
    check("overrun rx_valid held", {31'd0, valid_w[0]}, 1);

    // Same again, with ready high only in the delivery cycle of 0x22.
    snap(0);
    align();
    n0 = cyc;
    fork
      send_frame(0, 8'h22, 0, 1'b0, 1'b1);
      begin
        while (cyc < n0 + lat - 1) cycles(1);
        rdy_w[0] = 1'b1;
        cycles(1);
        rdy_w[0] = 1'b0;
      end
    join
    cycles(32);
    check("reload rx_data", {24'd0, data_w[0]}, 32'h22);
    check("reload no overrun", n_ovr[0] - s_ovr, 0);
    check("reload rx_valid stays high", n_rise[0] - s_rise, 0);
    check("reload rx_valid", {31'd0, valid_w[0]}, 1);

    // Reset during data bit 3 of 0xFF while 0x22 is still pending.
    align();
    fork
      send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
      begin
        cycles(4 * BIT_CLK + 32);
        check("mid-frame busy", {31'd0, busy_w[0]}, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst rx_valid", {30'd0, valid_w}, 0);
        check("rst rx_data", {24'd0, data_w[0]}, 0);
        check("rst busy", {30'd0, busy_w}, 0);
        check("rst err flags", {26'd0, ferr_w, perr_w, ovr_w}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    cycles(32);
    check("post-rst no spurious byte", {31'd0, valid_w[0]}, 0);
    snap(0);
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    cycles(32);
    check("post-rst 5A received", n_rise[0] - s_rise, 1);
    check("post-rst 5A rx_data", {24'd0, rise_data[0]}, 32'h5A);

    // Randomized 8N1 frames with a random consumer, checked against a
    // one-entry mailbox model.
    consume(0);
    m_pend    = 1'b0;
    m_data    = 8'h00;
    exp_ovr   = 0;
    exp_ferr  = 0;
    base_ovr  = n_ovr[0];
    base_ferr = n_ferr[0];
    for (int k = 0; k < 16; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(0, b, 0, 1'b0, !bad);
      rx_w[0] = 1'b1;
      cycles(48);
      if (bad) exp_ferr++;
      else if (m_pend) exp_ovr++;
      else begin
        m_pend = 1'b1;
        m_data = b;
      end
      check($sformatf("rnd%0d rx_valid", k), {31'd0, valid_w[0]}, {31'd0, m_pend});
      if (m_pend) check($sformatf("rnd%0d rx_data", k), {24'd0, data_w[0]}, {24'd0, m_data});
      check($sformatf("rnd%0d overruns", k), n_ovr[0] - base_ovr, exp_ovr);
      check($sformatf("rnd%0d frame errs", k), n_ferr[0] - base_ferr, exp_ferr);
      if ($urandom_range(0, 1) == 1) begin
        consume(0);
        m_pend = 1'b0;
      end
      cycles($urandom_range(0, 7));
    end

    // Randomized 8E1 frames, parity bit right or wrong at random.
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 2) != 0);
      pb   = good ? (^b) : ~(^b);
      snap(1);
      send_frame(1, b, 1, pb, 1'b1);
      cycles(32);
      check($sformatf("prnd%0d rx_valid", k), n_rise[1] - s_rise, {31'd0, good});
      check($sformatf("prnd%0d parity_err", k), n_perr[1] - s_perr, {31'd0, !good});
      if (good) check($sformatf("prnd%0d rx_data", k), {24'd0, rise_data[1]}, {24'd0, b});
      cycles($urandom_range(0, 7));
    end

    // Whole-run properties gathered by the monitor.
    check("error pulse width", n_wide, 0);
    check("simultaneous error flags", n_multi, 0);
    check("rx_data stable while valid", n_unstable, 0);
    check("8N1 never reports parity_err", n_perr[0], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_16x.md
UART_RX_16X -- requirements
Module: uart_rx_16x

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter PARITY_EN, default 0, where 1 means a parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, where 0 means even parity and 1 means odd parity; it is ignored when PARITY_EN=0.
REQ-004 SHALL have port clk, input, 1 bit, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port baud_tick_16x, input, 1 bit, one-clk pulse at 16x the baud rate from the baud generator.
REQ-007 SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-008 SHALL have port rx_ready, input, 1 bit, consumer accepts rx_data when high with rx_valid.
REQ-009 SHALL have port rx_data, output, 8 bits, received byte, LSB-aligned, unused MSBs 0.
REQ-010 SHALL have port rx_valid, output, 1 bit, rx_data holds an unconsumed byte.
REQ-011 SHALL have port frame_err, output, 1 bit, one-clk pulse when the stop bit is sampled low.
REQ-012 SHALL have port parity_err, output, 1 bit, one-clk pulse when the parity check fails.
REQ-013 SHALL have port overrun_err, output, 1 bit, one-clk pulse when a good byte arrives while rx_valid is pending.
REQ-014 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-016 SHALL use a 4-bit tick counter and a 3-bit bit counter, advanced only in clk cycles with baud_tick_16x=1; with no tick, state and counters are held.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-018 IDLE: on a tick with rx_s=0, SHALL go to START with tick_cnt=0.
REQ-019 START: SHALL increment tick_cnt per tick; at the tick where tick_cnt=7, if rx_s=1 (glitch) SHALL go to IDLE with no output, else SHALL clear tick_cnt and go to DATA.
REQ-020 DATA: at the tick where tick_cnt=15 (mid-bit), SHALL sample rx_s into the shift register LSB-first, clear tick_cnt and increment bit_cnt.
REQ-021 DATA: after sample number DATA_BITS, SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-022 PARITY: at tick_cnt=15, SHALL sample rx_s and compare it with the XOR of the data bits (inverted if PARITY_ODD); a mismatch marks the frame bad-parity; then SHALL go to STOP.
REQ-023 STOP: at tick_cnt=15, SHALL sample rx_s; if rx_s=1 and parity is good, SHALL deliver the byte (REQ-025) and go to IDLE.
REQ-024 STOP: if rx_s=0, SHALL pulse frame_err, discard the byte, and go to WAIT_IDLE; if parity is bad and rx_s=1, SHALL pulse parity_err, discard the byte, and go to IDLE.
REQ-025 Delivery: if rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle, SHALL load rx_data and set rx_valid=1 on the next edge.
REQ-026 Delivery: if rx_valid=1 and rx_ready=0, SHALL pulse overrun_err, keep the old rx_data, and drop the new byte.
REQ-027 Delivery SHALL occur one clk after the stop-bit sampling tick.
REQ-028 rx_valid SHALL stay high until a cycle with rx_valid=1 and rx_ready=1, and SHALL clear on the following edge unless REQ-025 reloads it.
REQ-029 rx_data SHALL be stable while rx_valid=1.
REQ-030 WAIT_IDLE (break/line low): SHALL remain there until a tick with rx_s=1, then go to IDLE; no new start is detected meanwhile.
REQ-031 Error pulses SHALL be exactly one clk wide, and more than one error flag SHALL never be high in the same cycle.

Reset
REQ-032 While rst=1, at any point including mid-frame, SHALL force state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data=0, rx_valid=0, all error outputs 0, busy=0.
REQ-033 The first start detection after reset SHALL require rx_s=0 observed on a tick after rst deasserts.

Verification
REQ-034 Bench SHALL check: tick every 4 clk, DATA_BITS=8, no parity, send 0xA5 with a good stop bit -> rx_valid rises once, rx_data=0xA5, no error pulses.
REQ-035 Bench SHALL check: rx low for 4 ticks then high -> no rx_valid, busy returns 0 after the tick with tick_cnt=7.
REQ-036 Bench SHALL check: send 0x3C with stop bit 0, hold rx low 40 ticks, then high -> exactly one frame_err pulse, rx_valid stays 0, busy remains high until the first tick with rx_s=1.
REQ-037 Bench SHALL check: PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> one parity_err pulse, no rx_valid; the same frame with parity bit 1 -> rx_data=0x07.
REQ-038 Bench SHALL check: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, one overrun_err pulse; repeat with rx_ready=1 in the delivery cycle of 0x22 -> rx_data=0x22, no overrun.
REQ-039 Bench SHALL check: assert rst during DATA bit 3 of 0xFF -> all outputs at reset values next edge; a following 0x5A frame is received correctly.
